// File: rtl/pico_bram_ctrl.sv
// picorv32 native-bus slave for four byte-lane synchronous block RAMs sharing one word address.
// Writes complete in one cycle; reads take two, hiding the one-cycle RAM output latency.
module pico_bram_ctrl #(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int unsigned ADDR_BITS = 11
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        mem_valid,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   input  logic [3:0]  mem_wstrb,
   output logic        mem_ready,
   output logic [31:0] mem_rdata,
   output logic        hit,
   output logic [13:0] ram_ad,
   output logic [31:0] ram_di,
   output logic [3:0]  ram_sel,
   output logic        ram_wre,
   input  logic [31:0] ram_do
);

   localparam int unsigned TAG_LSB = ADDR_BITS + 2;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RD   = 2'd1,
      ST_ACK  = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic        mem_ready_q, mem_ready_d;
   logic [31:0] mem_rdata_q, mem_rdata_d;
   logic        req_s;
   logic [13:0] ram_ad_s;
   logic [3:0]  ram_sel_s;
   logic        ram_wre_s;
   logic        addr_lsb_unused_s;

   assign hit               = (mem_addr[31:TAG_LSB] == BASE_ADDR[31:TAG_LSB]);
   assign req_s             = mem_valid && hit;
   assign addr_lsb_unused_s = ^mem_addr[1:0];

   // Word address, zero-extended to the full 14-bit RAM address bus
   always_comb begin
      ram_ad_s                  = 14'd0;
      ram_ad_s[ADDR_BITS-1:0]   = mem_addr[ADDR_BITS+1:2];
   end

   assign ram_ad    = ram_ad_s;
   assign ram_di    = mem_wdata;
   assign ram_sel   = ram_sel_s;
   assign ram_wre   = ram_wre_s;
   assign mem_ready = mem_ready_q;
   assign mem_rdata = mem_rdata_q;

   // State, ready pulse and read-data registers
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q     <= ST_IDLE;
         mem_ready_q <= 1'b0;
         mem_rdata_q <= 32'h0000_0000;
      end else begin
         state_q     <= state_d;
         mem_ready_q <= mem_ready_d;
         mem_rdata_q <= mem_rdata_d;
      end
   end

   // Next-state logic; ACK never re-issues the still-asserted request
   always_comb begin
      state_d     = state_q;
      mem_ready_d = 1'b0;
      mem_rdata_d = mem_rdata_q;
      case (state_q)
         ST_IDLE: begin
            if (req_s) begin
               if (mem_wstrb != 4'h0) begin
                  state_d     = ST_ACK;
                  mem_ready_d = 1'b1;
               end else begin
                  state_d     = ST_RD;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RD: begin
            if (mem_valid) begin
               state_d     = ST_ACK;
               mem_ready_d = 1'b1;
               mem_rdata_d = ram_do;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_ACK: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // RAM strobes: only an accepted request in IDLE touches the RAM, never during reset
   always_comb begin
      ram_sel_s = 4'h0;
      ram_wre_s = 1'b0;
      if (resetn && (state_q == ST_IDLE) && req_s) begin
         if (mem_wstrb != 4'h0) begin
            ram_sel_s = mem_wstrb;
            ram_wre_s = 1'b1;
         end else begin
            ram_sel_s = 4'hF;
            ram_wre_s = 1'b0;
         end
      end else begin
         ram_sel_s = 4'h0;
         ram_wre_s = 1'b0;
      end
   end

endmodule

// File: doc/pico_bram_ctrl.md
Name: pico_bram_ctrl

Overview:
Bridges the picorv32 native memory interface onto four byte-lane 2048x8 dual-port block-RAM instances. All four instances use port A, with lane n storing bits 8n+7:8n. The controller decodes an address window, drives the RAM address, data, select and write-enable signals, absorbs the one-cycle synchronous RAM read latency, and returns a registered mem_ready/mem_rdata to the CPU. It sits between the CPU bus fabric and the byte-lane RAM wrappers.

Parameters:
BASE_ADDR, 32'h0000_0000, byte base address of the RAM window; must be aligned to the window size.
ADDR_BITS, 11, word-address width. Legal range 11..14. Window size is 4*2^ADDR_BITS bytes. Bits above 10 drive the RAM block-select bits.

Ports:
clk  in  1  system clock; all RAM ports clocked by the same clk
resetn  in  1  asynchronous active-low reset
mem_valid  in  1  CPU request valid; held until mem_ready
mem_addr  in  32  CPU byte address, word aligned
mem_wdata  in  32  CPU write data
mem_wstrb  in  4  byte write strobes; 4'h0 means read
mem_ready  out  1  registered one-cycle completion pulse
mem_rdata  out  32  registered read data
hit  out  1  combinational: mem_addr is inside the window
ram_ad  out  14  word address to all lanes; zero-extended mem_addr[ADDR_BITS+1:2]
ram_di  out  32  write data; equals mem_wdata
ram_sel  out  4  per-lane chip enable
ram_wre  out  1  write enable, shared by all lanes
ram_do  in  32  concatenated lane read data; valid the cycle after a read select

Behaviour:
- hit = (mem_addr[31:ADDR_BITS+2] == BASE_ADDR[31:ADDR_BITS+2]).
- req = mem_valid && hit.
- ram_ad and ram_di are combinational pass-throughs. They are don't-care when ram_sel == 0.

State machine: IDLE, RD, ACK. Reset state is IDLE.
- IDLE, req and mem_wstrb != 0:
  - ram_sel = mem_wstrb, ram_wre = 1.
  - Go to ACK. Set mem_ready register to 1 for the next cycle.
  - Write latency: mem_ready is high 1 cycle after mem_valid is first seen.
- IDLE, req and mem_wstrb == 0:
  - ram_sel = 4'hF, ram_wre = 0. Go to RD.
- IDLE, no req: ram_sel = 0, ram_wre = 0. Stay in IDLE.
- RD:
  - ram_sel = 0.
  - If mem_valid: capture mem_rdata <= ram_do, set mem_ready register to 1, go to ACK.
  - If mem_valid has dropped (illegal abort): go to IDLE with no ready and mem_rdata unchanged.
  - Read latency: mem_ready is high 2 cycles after mem_valid is first seen.
- ACK:
  - mem_ready is high for exactly this one cycle. ram_sel = 0.
  - Unconditionally go to IDLE; mem_ready clears.
  - A mem_valid still high in ACK is not re-issued. The CPU sees mem_ready and retires the request, so no duplicate write occurs.
- Back-to-back: a new request presented in the cycle after ACK is accepted in IDLE with no bubble.
  - Minimum spacing: 2 cycles per write, 3 cycles per read.

Reset and outputs:
- Reset values: state = IDLE, mem_ready = 0, mem_rdata = 32'h0.
- Combinational outputs reflect inputs gated by state. ram_sel = 0 and ram_wre = 0 while resetn is low.
- Reset asserted mid-transaction: immediate return to IDLE and mem_ready = 0. A write already clocked into RAM stays written. An in-flight read is discarded.

Other rules:
- mem_rdata holds its last read value between reads. Writes do not modify it.
- Out-of-window request: hit = 0, no RAM activity, no mem_ready. Another slave responds. The state machine stays in IDLE.
- Partial write with a sparse strobe, e.g. 4'b0101: only the selected lanes are enabled. Unselected bytes keep their contents.
- Address wrap: none inside the window. The top word 2^ADDR_BITS-1 is valid. The next word falls outside the window, so hit = 0.

Test Plan:
- Reset: hold resetn low with mem_valid = 1 -> mem_ready = 0, mem_rdata = 0, ram_sel = 0. Release reset -> the first request is accepted in IDLE.
- Word write then read:
  - write 0x0000_0010 = 32'hDEADBEEF, wstrb = 4'hF -> ram_sel = 4'hF, ram_wre = 1, ram_ad = 14'd4; mem_ready exactly 1 cycle later.
  - read the same address -> mem_ready 2 cycles after valid, mem_rdata = 32'hDEADBEEF.
- Byte strobes: over 32'hDEADBEEF at 0x10, write 32'h11223344 with wstrb = 4'b0101 -> ram_sel = 4'b0101; readback = 32'hDE22BE44.
- Window and block-select (ADDR_BITS = 13, BASE_ADDR = 32'h0001_0000):
  - access 0x0001_7FFC -> hit = 1, ram_ad = 14'h1FFF.
  - access 0x0001_8000 and 0x0000_0000 -> hit = 0, no ram_sel, no mem_ready.
- Back-to-back: write, read, read to consecutive words with mem_valid reasserted the cycle after each ready -> exactly one ram_sel pulse per request, no duplicate writes, correct data for each read.
- Reset mid-read: assert resetn low during RD -> mem_ready is never asserted, state is IDLE after release, mem_rdata = 0.
